// File: rtl/aq_pmp_chk_ctrl.sv
// rtl/aq_pmp_chk_ctrl.sv - PMP check sequencer: begin/end phase control, lowest-index priority resolve, MMU response
module aq_pmp_chk_ctrl #(
  parameter  int ENTRY_NUM  = 8,
  parameter  int ADDR_WIDTH = 28,
  localparam int IDX_W      = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  mmu_pmp_req,
  input  logic [ADDR_WIDTH-1:0] mmu_pmp_req_pa,
  input  logic [ADDR_WIDTH-1:0] mmu_pmp_req_end_pa,
  input  logic                  mmu_pmp_req_cross,
  input  logic [1:0]            mmu_pmp_req_type,
  input  logic [1:0]            mmu_pmp_req_priv,
  input  logic                  mmu_pmp_abort,
  input  logic                  mmu_pmp_rsp_ack,
  input  logic                  cp0_pmp_upd,
  input  logic [ENTRY_NUM-1:0]  pmp_mmu_hit,
  input  logic [ENTRY_NUM-1:0]  napot_cross,
  input  logic [ENTRY_NUM-1:0]  pmp_entry_napot,
  input  logic [ENTRY_NUM-1:0]  pmpcfg_r,
  input  logic [ENTRY_NUM-1:0]  pmpcfg_w,
  input  logic [ENTRY_NUM-1:0]  pmpcfg_x,
  input  logic [ENTRY_NUM-1:0]  pmpcfg_l,
  output logic [ADDR_WIDTH-1:0] mmu_pmp_pa,
  output logic                  mmu_pmp_chk1,
  output logic                  pmp_mmu_busy,
  output logic                  pmp_mmu_rsp_vld,
  output logic                  pmp_mmu_fault,
  output logic                  pmp_mmu_fault_cross,
  output logic [IDX_W-1:0]      pmp_mmu_hit_idx
);

  typedef enum logic [1:0] {IDLE, CHK0, CHK1, RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pa;
  logic [ADDR_WIDTH-1:0] r_end_pa;
  logic                  r_cross;
  logic [1:0]            r_type;
  logic [1:0]            r_priv;
  logic [IDX_W-1:0]      r_idx0;
  logic                  r_any0;
  logic                  r_fault0;
  logic                  r_fcross0;
  logic                  r_fault;
  logic                  r_fcross;
  logic [IDX_W-1:0]      r_idx;

  logic [IDX_W-1:0]      w_idx;
  logic                  w_any;
  logic                  w_mmode;
  logic                  w_perm;
  logic                  w_fault;
  logic                  w_fcross;
  logic                  w_mism;

  // Phase resolve: descending scan so the lowest hitting index is written last and wins.
  always_comb begin
    w_idx    = '0;
    w_any    = 1'b0;
    w_perm   = 1'b0;
    w_fault  = 1'b0;
    w_fcross = 1'b0;
    w_mmode  = (r_priv == 2'b11);
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (pmp_mmu_hit[i]) begin
        w_idx = IDX_W'(i);
        w_any = 1'b1;
      end
    end
    case (r_type)
      2'b00:   w_perm = pmpcfg_r[w_idx];
      2'b01:   w_perm = pmpcfg_w[w_idx];
      2'b10:   w_perm = pmpcfg_x[w_idx];
      default: w_perm = 1'b0;
    endcase
    if (!w_any) begin
      w_fault = !w_mmode;
    end else if (!w_mmode || pmpcfg_l[w_idx]) begin
      w_fault = !w_perm;
    end
    if (w_any && pmp_entry_napot[w_idx] && !napot_cross[w_idx]) begin
      w_fault  = 1'b1;
      w_fcross = 1'b1;
    end
    if (r_type == 2'b11) begin
      w_fault = 1'b1;
    end
    w_mism = (w_any != r_any0) || (w_idx != r_idx0);
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    mmu_pmp_pa   = mmu_pmp_req_pa;
    mmu_pmp_chk1 = 1'b0;
    case (r_state)
      IDLE: begin
        if (mmu_pmp_req) w_state_nxt = CHK0;
      end
      CHK0: begin
        mmu_pmp_pa = r_pa;
        if (cp0_pmp_upd)  w_state_nxt = CHK0;
        else if (r_cross) w_state_nxt = CHK1;
        else              w_state_nxt = RESP;
      end
      CHK1: begin
        mmu_pmp_pa   = r_end_pa;
        mmu_pmp_chk1 = 1'b1;
        w_state_nxt  = cp0_pmp_upd ? CHK0 : RESP;
      end
      RESP: begin
        mmu_pmp_pa = r_pa;
        if (mmu_pmp_rsp_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (mmu_pmp_abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_pa      <= '0;
      r_end_pa  <= '0;
      r_cross   <= 1'b0;
      r_type    <= 2'b00;
      r_priv    <= 2'b00;
      r_idx0    <= '0;
      r_any0    <= 1'b0;
      r_fault0  <= 1'b0;
      r_fcross0 <= 1'b0;
      r_fault   <= 1'b0;
      r_fcross  <= 1'b0;
      r_idx     <= '0;
    end else begin
      if (r_state == IDLE && w_state_nxt == CHK0) begin
        r_pa     <= mmu_pmp_req_pa;
        r_end_pa <= mmu_pmp_req_end_pa;
        r_cross  <= mmu_pmp_req_cross;
        r_type   <= mmu_pmp_req_type;
        r_priv   <= mmu_pmp_req_priv;
      end
      if (r_state == CHK0 && !cp0_pmp_upd) begin
        r_idx0    <= w_idx;
        r_any0    <= w_any;
        r_fault0  <= w_fault;
        r_fcross0 <= w_fcross;
      end
      // Response fields read zero outside RESP so a stale result is never visible.
      if (w_state_nxt == RESP && r_state == CHK0) begin
        r_fault  <= w_fault;
        r_fcross <= w_fcross;
        r_idx    <= w_idx;
      end else if (w_state_nxt == RESP && r_state == CHK1) begin
        r_fault  <= r_fault0 | w_fault | w_mism;
        r_fcross <= r_fcross0 | w_fcross | w_mism;
        r_idx    <= r_idx0;
      end else if (w_state_nxt != RESP) begin
        r_fault  <= 1'b0;
        r_fcross <= 1'b0;
        r_idx    <= '0;
      end
    end
  end

  assign pmp_mmu_busy        = (r_state != IDLE);
  assign pmp_mmu_rsp_vld     = (r_state == RESP);
  assign pmp_mmu_fault       = r_fault;
  assign pmp_mmu_fault_cross = r_fcross;
  assign pmp_mmu_hit_idx     = r_idx;

endmodule
